cpu_hatch_server: RTL and testbench
===================================

// Module: cpu_hatch_server
// PURPOSE
//  Instruction-store responder on the far side of the CPU hatch. It answers
//  hatch_address with a 48-bit hatch_instruction one cycle later. A byte-wide
//  host loader fills the store, and the block holds the CPU in reset
//  (cpu_rst_b low) until a load completes.
// PARAMETERS
//  ADDR_W    10      log2 of store depth in instruction words (DEPTH=2**ADDR_W)
//  NOP_INSN  48'h0   word returned for out-of-range addresses and while not RUN
// PORTS
//  clk               in   1   clock
//  rst               in   1   async reset, active high
//  hatch_address     in   32  instruction word index requested by the CPU fetch
//  hatch_instruction out  48  instruction word, registered
//  cpu_rst_b         out  1   active-low reset to the CPU, registered
//  ld_start          in   1   pulse: begin a new load at word 0
//  ld_valid          in   1   ld_data is valid this cycle
//  ld_ready          out  1   block accepts ld_data (high only in LOAD)
//  ld_data           in   8   load byte; MSB-first within each 48-bit word
//  ld_done           in   1   pulse: load finished; enter RUN
//  ld_ovf            out  1   sticky: a word write was dropped (store full)
//  ld_count          out  ADDR_W+1  number of complete words written
// BEHAVIOUR
//  Reset values: hatch_instruction=NOP_INSN, cpu_rst_b=0, ld_ready=0,
//   ld_ovf=0, ld_count=0, state=IDLE, byte counter=0, staging reg=0.
//  States:
//   IDLE: ld_start goes to LOAD. Every other input is ignored.
//   LOAD: ld_done goes to RUN. ld_start restarts the load.
//   RUN:  ld_start goes to LOAD.
//  Reset mid-operation: rst returns to IDLE. The store contents are kept
//   (RAM is not reset).
//  Entering LOAD (from any state): byte count=0, word pointer=0,
//   ld_count=0, ld_ovf=0, and cpu_rst_b drops to 0 the next cycle.
//  Byte transfer: a byte is accepted when ld_valid & ld_ready. The byte
//   shifts into the 48-bit staging register from the LSB end, so the first
//   byte accepted becomes bits [47:40].
//  Sixth byte of a word:
//   - The word is written at the word pointer, the pointer increments and
//     ld_count increments, all in the same cycle.
//   - If the pointer has reached DEPTH, the write is dropped, ld_ovf is set,
//     and the pointer and ld_count saturate at DEPTH.
//  Same-cycle priority: ld_start > ld_done > byte acceptance.
//   - ld_start and ld_done together: ld_start wins.
//   - ld_done with an accepted byte: the byte is discarded.
//  On ld_done: any partial word (1-5 bytes staged) is discarded.
//   LOAD->RUN, and cpu_rst_b rises 1 cycle after entering RUN (2 cycles
//   after ld_done), so the CPU leaves reset with a stable store.
//  Read port: synchronous, 1-cycle latency.
//   - In RUN, hatch_address[31:ADDR_W]==0 gives
//     hatch_instruction <= mem[hatch_address[ADDR_W-1:0]] on the next edge.
//   - Any upper bit set gives NOP_INSN.
//   - Outside RUN, hatch_instruction <= NOP_INSN.
//  Words never written return the stale RAM contents; no valid tracking.
//  Write and read at the same address in the same cycle cannot occur,
//   because reads only happen in RUN and writes only in LOAD.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs at their reset values
//    immediately (async); hatch_instruction=NOP_INSN, cpu_rst_b=0.
//  2 Load/run: ld_start, bytes 01..0C, ld_done -> ld_count=2, cpu_rst_b=1
//    two cycles after ld_done; addr 0 -> 48'h010203040506 and addr 1 ->
//    48'h0708090A0B0C, each one cycle after the address is presented.
//  3 Partial word: ld_start, 8 bytes, ld_done -> ld_count=1; bytes 7-8
//    are discarded; word 1 keeps its old value.
//  4 Overflow (ADDR_W=2): load 5 words -> ld_count=4, ld_ovf=1; word 0 is
//    not overwritten.
//  5 Out of range: RUN with hatch_address=32'h0000_0400 (ADDR_W=10) ->
//    NOP_INSN; then 32'h3FF -> mem[1023].
//  6 Reload: ld_start in RUN -> cpu_rst_b=0 next cycle, ld_count=0,
//    ld_ovf cleared; ld_valid held high without ld_ready in IDLE -> nothing
//    written.

Source files
------------

// File: rtl/cpu_hatch_server.sv
// Instruction store behind the CPU hatch: byte-wide host loader fills 48-bit words,
// CPU fetches them with one-cycle latency and is held in reset until a load completes.
module cpu_hatch_server #(
    parameter int          ADDR_W   = 10,
    parameter logic [47:0] NOP_INSN = 48'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       hatch_address,
    output logic [47:0]       hatch_instruction,
    output logic              cpu_rst_b,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_done,
    output logic              ld_ovf,
    output logic [ADDR_W:0]   ld_count
);

    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [47:0]     stage_q, stage_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            rstb_q;
    logic            rd_sel_q;
    logic [47:0]     rd_q;
    logic            wr_en;
    logic [47:0]     wr_data;
    logic            accept;
    logic            in_range;
    logic [47:0]     mem [DEPTH];

    assign ld_ready  = (state_q == LOAD);
    assign accept    = ld_ready && ld_valid && !ld_start && !ld_done;
    assign in_range  = (hatch_address[31:ADDR_W] == '0);
    assign wr_data   = {stage_q[39:0], ld_data};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        stage_d    = stage_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;
        if (ld_start) begin
            state_d    = LOAD;
            byte_cnt_d = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
        end else if (state_q == LOAD && ld_done) begin
            // A partially staged word is dropped; only whole words count.
            state_d    = RUN;
            byte_cnt_d = '0;
        end else if (accept) begin
            stage_d = wr_data;
            if (byte_cnt_q == 3'd5) begin
                byte_cnt_d = '0;
                if (count_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + (ADDR_W + 1)'(1);
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            stage_q    <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rstb_q     <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            stage_q    <= stage_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            // CPU reset follows the RUN state one cycle late so the store is stable first.
            rstb_q     <= (state_q == RUN);
            rd_sel_q   <= (state_q == RUN) && in_range;
        end
    end

    // Store array carries no reset so it maps onto block RAM and survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[ADDR_W-1:0]] <= wr_data;
        end
        rd_q <= mem[hatch_address[ADDR_W-1:0]];
    end

    assign hatch_instruction = rd_sel_q ? rd_q : NOP_INSN;
    assign cpu_rst_b         = rstb_q;
    assign ld_ovf            = ovf_q;
    assign ld_count          = count_q;

endmodule

// File: tb/tb_cpu_hatch_server.sv
// Bench for cpu_hatch_server: two instances (ADDR_W=10 and ADDR_W=2) driven in parallel
// and checked every cycle against a word-level model of the loader and store.
module tb_cpu_hatch_server;

    localparam logic [47:0] NOP10 = 48'h0;
    localparam logic [47:0] NOP2  = 48'hDEAD_BEEF_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] hatch_address = '0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_done  = 1'b0;
    logic [7:0]  ld_data  = '0;

    wire [47:0] insn10, insn2;
    wire        rstb10, rstb2, rdy10, rdy2, ovf10, ovf2;
    wire [10:0] cnt10;
    wire [2:0]  cnt2;

    always #5 clk = ~clk;

    cpu_hatch_server #(.ADDR_W(10), .NOP_INSN(NOP10)) u10 (
        .clk(clk), .rst(rst), .hatch_address(hatch_address), .hatch_instruction(insn10),
        .cpu_rst_b(rstb10), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(rdy10),
        .ld_data(ld_data), .ld_done(ld_done), .ld_ovf(ovf10), .ld_count(cnt10)
    );

    cpu_hatch_server #(.ADDR_W(2), .NOP_INSN(NOP2)) u2 (
        .clk(clk), .rst(rst), .hatch_address(hatch_address), .hatch_instruction(insn2),
        .cpu_rst_b(rstb2), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(rdy2),
        .ld_data(ld_data), .ld_done(ld_done), .ld_ovf(ovf2), .ld_count(cnt2)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: mode 0=idle 1=load 2=run, one entry per instance.
    int          m_mode [2];
    int          m_nb   [2];
    logic [47:0] m_acc  [2];
    int          m_cnt  [2];
    bit          m_ovf  [2];
    logic [47:0] m_mem  [2][1024];
    bit          m_known[2][1024];
    logic [47:0] e_insn [2];
    bit          e_ok   [2];
    bit          e_rstb [2];

    function automatic int dep(input int k);
        return (k == 0) ? 1024 : 4;
    endfunction

    function automatic logic [47:0] nop(input int k);
        return (k == 0) ? NOP10 : NOP2;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_nb[k] = 0; m_acc[k] = '0; m_cnt[k] = 0; m_ovf[k] = 0;
            e_insn[k] = nop(k); e_ok[k] = 1; e_rstb[k] = 0;
            for (int a = 0; a < 1024; a++) m_known[k][a] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = 0; m_nb[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                e_insn[k] = nop(k); e_ok[k] = 1; e_rstb[k] = 0;
            end else begin
                if (m_mode[k] == 2 && hatch_address < 32'(dep(k))) begin
                    e_insn[k] = m_mem[k][hatch_address[9:0]];
                    e_ok[k]   = m_known[k][hatch_address[9:0]];
                end else begin
                    e_insn[k] = nop(k);
                    e_ok[k]   = 1;
                end
                e_rstb[k] = (m_mode[k] == 2);
                if (ld_start) begin
                    m_mode[k] = 1; m_nb[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                end else if (m_mode[k] == 1) begin
                    if (ld_done) begin
                        m_mode[k] = 2; m_nb[k] = 0;
                    end else if (ld_valid) begin
                        m_acc[k] = {m_acc[k][39:0], ld_data};
                        m_nb[k]++;
                        if (m_nb[k] == 6) begin
                            m_nb[k] = 0;
                            if (m_cnt[k] < dep(k)) begin
                                m_mem[k][m_cnt[k]]   = m_acc[k];
                                m_known[k][m_cnt[k]] = 1;
                                m_cnt[k]++;
                            end else begin
                                m_ovf[k] = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on && !rst) begin
            if (e_ok[0]) check("insn10", 64'(insn10), 64'(e_insn[0]));
            if (e_ok[1]) check("insn2", 64'(insn2), 64'(e_insn[1]));
            check("rstb10", 64'(rstb10), 64'(e_rstb[0]));
            check("rstb2",  64'(rstb2),  64'(e_rstb[1]));
            check("rdy10",  64'(rdy10),  64'(m_mode[0] == 1));
            check("rdy2",   64'(rdy2),   64'(m_mode[1] == 1));
            check("ovf10",  64'(ovf10),  64'(m_ovf[0]));
            check("ovf2",   64'(ovf2),   64'(m_ovf[1]));
            check("cnt10",  64'(cnt10),  64'(m_cnt[0]));
            check("cnt2",   64'(cnt2),   64'(m_cnt[1]));
        end
    end

    task automatic pulse_start();
        ld_start = 1'b1; @(negedge clk); ld_start = 1'b0;
    endtask

    task automatic pulse_done();
        ld_done = 1'b1; @(negedge clk); ld_done = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        ld_valid = 1'b1; ld_data = b; @(negedge clk); ld_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        hatch_address = a; @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_insn10", 64'(insn10), 64'(NOP10));
        check("rst_insn2",  64'(insn2),  64'(NOP2));
        check("rst_rstb10", 64'(rstb10), 64'd0);
        check("rst_rdy10",  64'(rdy10),  64'd0);
        check("rst_ovf2",   64'(ovf2),   64'd0);
        check("rst_cnt10",  64'(cnt10),  64'd0);
        check("rst_cnt2",   64'(cnt2),   64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [47:0] lastw;
    logic [47:0] w;

    initial begin
        @(negedge clk);
        do_reset();
        chk_on = 1'b1;

        // Two full words then done
        pulse_start();
        for (int b = 1; b <= 12; b++) put_byte(8'(b));
        pulse_done();
        check("t2_rstb_held", 64'(rstb10), 64'd0);
        @(negedge clk);
        check("t2_rstb_up", 64'(rstb10), 64'd1);
        check("t2_cnt", 64'(cnt10), 64'd2);
        rd(32'd0);
        check("t2_w0", 64'(insn10), 64'h0000_0102_0304_0506);
        rd(32'd1);
        check("t2_w1", 64'(insn10), 64'h0000_0708_090A_0B0C);

        // Partial trailing word is discarded
        pulse_start();
        for (int b = 0; b < 8; b++) put_byte(8'h11 + 8'(b));
        pulse_done();
        @(negedge clk);
        check("t3_cnt", 64'(cnt10), 64'd1);
        rd(32'd0);
        check("t3_w0", 64'(insn10), 64'h0000_1112_1314_1516);
        rd(32'd1);
        check("t3_w1_kept", 64'(insn10), 64'h0000_0708_090A_0B0C);

        // Five words: the ADDR_W=2 store overflows
        pulse_start();
        for (int b = 0; b < 30; b++) put_byte(8'h20 + 8'(b));
        pulse_done();
        @(negedge clk);
        check("t4_cnt2", 64'(cnt2), 64'd4);
        check("t4_ovf2", 64'(ovf2), 64'd1);
        check("t4_cnt10", 64'(cnt10), 64'd5);
        check("t4_ovf10", 64'(ovf10), 64'd0);
        rd(32'd0);
        check("t4_w0_kept", 64'(insn2), 64'h0000_2021_2223_2425);
        rd(32'd3);
        check("t4_w3", 64'(insn2), 64'h0000_3233_3435_3637);
        rd(32'd4);
        check("t4_oor2", 64'(insn2), 64'(NOP2));
        check("t4_w4_10", 64'(insn10), 64'h0000_3839_3A3B_3C3D);

        // Fill the full 1024-word store with random words, with occasional gaps
        pulse_start();
        lastw = '0;
        for (int i = 0; i < 1024; i++) begin
            w = {16'($urandom), $urandom};
            lastw = w;
            for (int j = 5; j >= 0; j--) begin
                if ($urandom_range(0, 7) == 0) @(negedge clk);
                put_byte(w[j*8 +: 8]);
            end
        end
        pulse_done();
        @(negedge clk);
        check("t5_cnt10", 64'(cnt10), 64'd1024);
        check("t5_ovf10", 64'(ovf10), 64'd0);
        rd(32'h0000_0400);
        check("t5_oor", 64'(insn10), 64'(NOP10));
        rd(32'h0000_03FF);
        check("t5_last", 64'(insn10), 64'(lastw));
        rd(32'h8000_0000);
        check("t5_hibit", 64'(insn10), 64'(NOP10));

        // Reload from RUN
        pulse_start();
        check("t6_cnt", 64'(cnt10), 64'd0);
        check("t6_ovf2_clr", 64'(ovf2), 64'd0);
        @(negedge clk);
        check("t6_rstb_drop", 64'(rstb10), 64'd0);
        for (int b = 0; b < 6; b++) put_byte(8'hAA + 8'(b*17));
        put_byte(8'h01);
        put_byte(8'h02);

        // Asynchronous reset in the middle of a load
        do_reset();

        // ld_valid held in IDLE must not be taken
        ld_valid = 1'b1; ld_data = 8'h55;
        repeat (20) @(negedge clk);
        ld_valid = 1'b0;
        check("t6_idle_cnt", 64'(cnt10), 64'd0);
        pulse_start();
        pulse_done();
        @(negedge clk);
        check("t6_idle_nowr", 64'(cnt10), 64'd0);
        rd(32'd0);
        check("t6_w0", 64'(insn10), 64'h0000_AABB_CCDD_EEFF);

        // Priority: start beats done, done beats byte
        pulse_start();
        for (int b = 0; b < 5; b++) put_byte(8'h50 + 8'(b));
        ld_start = 1'b1; ld_done = 1'b1;
        @(negedge clk);
        ld_start = 1'b0; ld_done = 1'b0;
        check("t7_start_wins", 64'(rdy10), 64'd1);
        for (int b = 0; b < 6; b++) put_byte(8'h61 + 8'(b));
        ld_done = 1'b1; ld_valid = 1'b1; ld_data = 8'h77;
        @(negedge clk);
        ld_done = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        check("t7_cnt", 64'(cnt10), 64'd1);
        rd(32'd0);
        check("t7_w0", 64'(insn10), 64'h0000_6162_6364_6566);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            ld_start = ($urandom_range(0, 150) == 0);
            ld_done  = ($urandom_range(0, 60) == 0);
            ld_valid = $urandom_range(0, 1) == 1;
            ld_data  = 8'($urandom);
            hatch_address = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 1030)) : $urandom;
            @(negedge clk);
        end
        ld_start = 1'b0; ld_done = 1'b0; ld_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
